// File: rtl/cache_trace_capture_if.sv
// cache_trace_capture_if
//  Groups the two buses that cross the cache_trace_capture boundary:
//   request side  : req_valid, rw, address     (sniffed cache requests)
//   drain side    : out_valid, out_ready, out_rw, out_addr (host record stream)
//  master : the environment side that drives requests and out_ready
//  slave  : the capture block, which receives requests and presents records
interface cache_trace_capture_if #(
  parameter int ADDRESS_SIZE = 16
);
  logic                    req_valid;
  logic                    rw;
  logic [ADDRESS_SIZE-1:0] address;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_rw;
  logic [ADDRESS_SIZE-1:0] out_addr;

  modport master (
    output req_valid, rw, address, out_ready,
    input  out_valid, out_rw, out_addr
  );

  modport slave (
    input  req_valid, rw, address, out_ready,
    output out_valid, out_rw, out_addr
  );
endinterface

// File: rtl/cache_trace_capture.sv
// cache_trace_capture
//  Sniffs cache requests {rw, address} into an on-chip trace FIFO while in
//  CAPTURE, and lets a host drain the records in arrival order over a
//  valid/ready port. Keeps saturating read/write/drop counters.
// Ports
//  clk        clock, all state on posedge
//  reset      synchronous, active-high
//  start      pulse: IDLE/STOPPED -> CAPTURE
//  stop       pulse: CAPTURE -> STOPPED (wins over start)
//  clear      pulse: flush FIFO, zero counters, go IDLE (wins over everything)
//  bus        slave side of cache_trace_capture_if (request + drain buses)
//  level      FIFO occupancy, 0..DEPTH
//  capturing  high while in CAPTURE
//  overflow   sticky: a request was dropped since reset/clear
//  n_reads    accepted read records
//  n_writes   accepted write records
//  n_dropped  requests lost to a full FIFO while capturing
module cache_trace_capture #(
  parameter int ADDRESS_SIZE = 16,
  parameter int DEPTH        = 16,
  parameter int COUNT_W      = 32,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     clear,
  cache_trace_capture_if.slave     bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     capturing,
  output logic                     overflow,
  output logic [COUNT_W-1:0]       n_reads,
  output logic [COUNT_W-1:0]       n_writes,
  output logic [COUNT_W-1:0]       n_dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STOPPED
  } state_t;

  state_t state, state_next;

  logic [ADDRESS_SIZE:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_next;
  logic [ADDRESS_SIZE:0] head;
  logic                  full, push_req, pop, push_ok, drop;

  assign full     = (level == FULL_LEVEL);
  assign push_req = (state == CAPTURE) && bus.req_valid;
  // A pop frees a slot in the same edge, so a push into a full FIFO still
  // lands when the head is being taken.
  assign pop      = (level != '0) && bus.out_ready;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    level_next = level;
    if (push_ok && !pop) begin
      level_next = level + LW'(1);
    end else if (pop && !push_ok) begin
      level_next = level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Auto-stop looks at the post-edge level so CAPTURE is left on the very
  // edge the FIFO becomes full and no push can ever be dropped then.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, STOPPED: begin
          if (start && !stop) begin
            state_next = CAPTURE;
          end
        end
        CAPTURE: begin
          if (stop) begin
            state_next = STOPPED;
          end else if (STOP_ON_FULL && (level_next == FULL_LEVEL)) begin
            state_next = STOPPED;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      n_reads   <= '0;
      n_writes  <= '0;
      n_dropped <= '0;
    end else begin
      level <= level_next;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (n_dropped != '1) begin
          n_dropped <= n_dropped + COUNT_W'(1);
        end
      end
      if (push_ok && !bus.rw && (n_reads != '1)) begin
        n_reads <= n_reads + COUNT_W'(1);
      end
      if (push_ok && bus.rw && (n_writes != '1)) begin
        n_writes <= n_writes + COUNT_W'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible while level covers them.
  always_ff @(posedge clk) begin
    if (push_ok && !reset && !clear) begin
      mem[wr_ptr] <= {bus.rw, bus.address};
    end
  end

  // Show-ahead head: a record written at an edge is visible right after it,
  // because an empty FIFO has rd_ptr == wr_ptr. Forced to zero when empty.
  assign head          = mem[rd_ptr];
  assign bus.out_valid = (level != '0);
  assign bus.out_rw    = bus.out_valid ? head[ADDRESS_SIZE] : 1'b0;
  assign bus.out_addr  = bus.out_valid ? head[ADDRESS_SIZE-1:0] : '0;
  assign capturing     = (state == CAPTURE);

endmodule

// File: tb/tb_cache_trace_capture.sv
// tb_cache_trace_capture
//  Drives two capture blocks in lockstep from one stimulus stream:
//   dut0 : STOP_ON_FULL=0, COUNT_W=32
//   dut1 : STOP_ON_FULL=1, COUNT_W=4 (small counters expose saturation)
//  A queue-based reference model, advanced on every clock edge, predicts
//  both blocks; directed scenario tasks also compare against fixed values.
`timescale 1ns/1ps
module tb_cache_trace_capture;

  localparam int AS    = 16;
  localparam int DEPTH = 16;

  typedef logic [AS:0] rec_t;
  typedef enum int {M_IDLE, M_CAPTURE, M_STOPPED} mstate_t;

  typedef struct packed {
    logic          valid;
    logic          rwb;
    logic [AS-1:0] addr;
    logic [4:0]    lvl;
    logic          cap;
    logic          ovf;
    logic [31:0]   rd;
    logic [31:0]   wr;
    logic [31:0]   dr;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, stop, clear, req_valid, rw, out_ready;
  logic [AS-1:0] address;

  int total;
  int bad;

  cache_trace_capture_if #(.ADDRESS_SIZE(AS)) bus0 ();
  cache_trace_capture_if #(.ADDRESS_SIZE(AS)) bus1 ();

  assign bus0.req_valid = req_valid;
  assign bus0.rw        = rw;
  assign bus0.address   = address;
  assign bus0.out_ready = out_ready;
  assign bus1.req_valid = req_valid;
  assign bus1.rw        = rw;
  assign bus1.address   = address;
  assign bus1.out_ready = out_ready;

  logic [4:0]  level0, level1;
  logic        capturing0, capturing1, overflow0, overflow1;
  logic [31:0] n_reads0, n_writes0, n_dropped0;
  logic [3:0]  n_reads1, n_writes1, n_dropped1;

  cache_trace_capture #(
    .ADDRESS_SIZE(AS), .DEPTH(DEPTH), .COUNT_W(32), .STOP_ON_FULL(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .bus(bus0), .level(level0), .capturing(capturing0), .overflow(overflow0),
    .n_reads(n_reads0), .n_writes(n_writes0), .n_dropped(n_dropped0)
  );

  cache_trace_capture #(
    .ADDRESS_SIZE(AS), .DEPTH(DEPTH), .COUNT_W(4), .STOP_ON_FULL(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .bus(bus1), .level(level1), .capturing(capturing1), .overflow(overflow1),
    .n_reads(n_reads1), .n_writes(n_writes1), .n_dropped(n_dropped1)
  );

  // Reference model: one record queue per block plus state and counters.
  rec_t            mq0[$];
  rec_t            mq1[$];
  mstate_t         mst [2];
  longint unsigned mrd [2];
  longint unsigned mwr [2];
  longint unsigned mdr [2];
  bit              mov [2];
  longint unsigned mmax[2];

  function automatic int msize(int m);
    return (m == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic rec_t mhead(int m);
    if (msize(m) == 0) return '0;
    return (m == 0) ? mq0[0] : mq1[0];
  endfunction

  // One clock edge of the behaviour, seen from the inputs applied before it.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (reset || clear) begin
        if (m == 0) mq0.delete(); else mq1.delete();
        mst[m] = M_IDLE;
        mrd[m] = 0;
        mwr[m] = 0;
        mdr[m] = 0;
        mov[m] = 1'b0;
      end else begin
        int   len;
        bit   do_pop;
        bit   do_push;
        rec_t r;
        len     = msize(m);
        do_pop  = (len > 0) && out_ready;
        do_push = (mst[m] == M_CAPTURE) && req_valid;
        r       = {rw, address};
        if (do_pop) begin
          if (m == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
        end
        if (do_push) begin
          if ((len < DEPTH) || do_pop) begin
            if (m == 0) mq0.push_back(r); else mq1.push_back(r);
            if (rw) begin
              if (mwr[m] < mmax[m]) mwr[m]++;
            end else begin
              if (mrd[m] < mmax[m]) mrd[m]++;
            end
          end else begin
            if (mdr[m] < mmax[m]) mdr[m]++;
            mov[m] = 1'b1;
          end
        end
        if (mst[m] == M_CAPTURE) begin
          if (stop) mst[m] = M_STOPPED;
          else if ((m == 1) && (msize(m) == DEPTH)) mst[m] = M_STOPPED;
        end else if (start && !stop) begin
          mst[m] = M_CAPTURE;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic snap_t snap(int m);
    snap_t s;
    if (m == 0) begin
      s.valid = bus0.out_valid; s.rwb = bus0.out_rw; s.addr = bus0.out_addr;
      s.lvl = level0; s.cap = capturing0; s.ovf = overflow0;
      s.rd = n_reads0; s.wr = n_writes0; s.dr = n_dropped0;
    end else begin
      s.valid = bus1.out_valid; s.rwb = bus1.out_rw; s.addr = bus1.out_addr;
      s.lvl = level1; s.cap = capturing1; s.ovf = overflow1;
      s.rd = 32'(n_reads1); s.wr = 32'(n_writes1); s.dr = 32'(n_dropped1);
    end
    return s;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; clear = 1'b0; req_valid = 1'b0;
    rw = 1'b0; address = '0; out_ready = 1'b0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    snap_t s;
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    for (int m = 0; m < 2; m++) begin
      s = snap(m);
      total++;
      if ({s.valid, s.rwb, s.addr} !== '0) begin
        bad++;
        $display("[TB] FAIL reset_out dut%0d got valid=%b rw=%b addr=%h want 0/0/0", m, s.valid, s.rwb, s.addr);
      end
      total++;
      if ({s.lvl, s.cap, s.ovf} !== '0) begin
        bad++;
        $display("[TB] FAIL reset_status dut%0d got level=%0d cap=%b ovf=%b want 0/0/0", m, s.lvl, s.cap, s.ovf);
      end
      total++;
      if ({s.rd, s.wr, s.dr} !== '0) begin
        bad++;
        $display("[TB] FAIL reset_counters dut%0d got r=%0d w=%0d d=%0d want 0", m, s.rd, s.wr, s.dr);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    rec_t  exp_rec[3];
    snap_t s;
    exp_rec[0] = {1'b0, 16'h1234};
    exp_rec[1] = {1'b1, 16'hBEEF};
    exp_rec[2] = {1'b0, 16'h0010};
    do_clear();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      {rw, address} = exp_rec[i];
      cycle();
    end
    req_valid = 1'b0;
    for (int m = 0; m < 2; m++) begin
      s = snap(m);
      total++;
      if (s.lvl !== 5'd3) begin
        bad++;
        $display("[TB] FAIL basic_level dut%0d got=%0d want=3", m, s.lvl);
      end
      total++;
      if ((s.rd !== 32'd2) || (s.wr !== 32'd1)) begin
        bad++;
        $display("[TB] FAIL basic_counts dut%0d got r=%0d w=%0d want r=2 w=1", m, s.rd, s.wr);
      end
    end
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int m = 0; m < 2; m++) begin
        s = snap(m);
        total++;
        if ((s.valid !== 1'b1) || ({s.rwb, s.addr} !== exp_rec[i])) begin
          bad++;
          $display("[TB] FAIL basic_drain%0d dut%0d got valid=%b rec=%h want valid=1 rec=%h", i, m, s.valid, {s.rwb, s.addr}, exp_rec[i]);
        end
      end
      cycle();
    end
    out_ready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      s = snap(m);
      total++;
      if ((s.lvl !== 5'd0) || (s.valid !== 1'b0)) begin
        bad++;
        $display("[TB] FAIL basic_empty dut%0d got level=%0d valid=%b want 0/0", m, s.lvl, s.valid);
      end
    end
  endtask

  task automatic test_overflow();
    snap_t s0, s1;
    do_clear();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      req_valid = 1'b1;
      rw        = i[0];
      address   = 16'h1000 + 16'(i);
      cycle();
      s1 = snap(1);
      if ((i == 14) || (i == 15)) begin
        total++;
        if (s1.cap !== (i == 14)) begin
          bad++;
          $display("[TB] FAIL autostop_push%0d got capturing=%b want %b", i + 1, s1.cap, (i == 14));
        end
      end
    end
    req_valid = 1'b0;
    s0 = snap(0);
    s1 = snap(1);
    total++;
    if ((s0.lvl !== 5'd16) || (s0.dr !== 32'd4) || (s0.ovf !== 1'b1) || (s0.cap !== 1'b1)) begin
      bad++;
      $display("[TB] FAIL overflow_status got level=%0d drop=%0d ovf=%b cap=%b want 16/4/1/1", s0.lvl, s0.dr, s0.ovf, s0.cap);
    end
    total++;
    if ((s0.rd !== 32'd8) || (s0.wr !== 32'd8)) begin
      bad++;
      $display("[TB] FAIL overflow_counts got r=%0d w=%0d want 8/8", s0.rd, s0.wr);
    end
    total++;
    if ((s1.lvl !== 5'd16) || (s1.dr !== 32'd0) || (s1.ovf !== 1'b0) || (s1.cap !== 1'b0)) begin
      bad++;
      $display("[TB] FAIL autostop_status got level=%0d drop=%0d ovf=%b cap=%b want 16/0/0/0", s1.lvl, s1.dr, s1.ovf, s1.cap);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rec_t want;
      want = {1'(i % 2), 16'h1000 + 16'(i)};
      for (int m = 0; m < 2; m++) begin
        s0 = snap(m);
        total++;
        if ((s0.valid !== 1'b1) || ({s0.rwb, s0.addr} !== want)) begin
          bad++;
          $display("[TB] FAIL overflow_drain%0d dut%0d got valid=%b rec=%h want valid=1 rec=%h", i, m, s0.valid, {s0.rwb, s0.addr}, want);
        end
      end
      cycle();
    end
    out_ready = 1'b0;
    s0 = snap(0);
    total++;
    if (s0.valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL overflow_empty got valid=%b want 0", s0.valid);
    end
  endtask

  task automatic test_full_pushpop();
    snap_t s;
    do_clear();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      address   = 16'h2000 + 16'(i);
      cycle();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      address = 16'h2010 + 16'(j);
      cycle();
      s = snap(0);
      total++;
      if (s.lvl !== 5'd16) begin
        bad++;
        $display("[TB] FAIL pushpop_level%0d got=%0d want=16", j, s.lvl);
      end
    end
    req_valid = 1'b0;
    out_ready = 1'b0;
    s = snap(0);
    total++;
    if ((s.dr !== 32'd0) || (s.ovf !== 1'b0)) begin
      bad++;
      $display("[TB] FAIL pushpop_nodrop got drop=%0d ovf=%b want 0/0", s.dr, s.ovf);
    end
    s = snap(1);
    total++;
    if (s.lvl !== 5'd11) begin
      bad++;
      $display("[TB] FAIL pushpop_stopped_level got=%0d want=11", s.lvl);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s = snap(0);
      total++;
      if ({s.valid, s.rwb, s.addr} !== {1'b1, 1'b0, 16'h2005 + 16'(i)}) begin
        bad++;
        $display("[TB] FAIL pushpop_drain%0d got valid=%b addr=%h want valid=1 addr=%h", i, s.valid, s.addr, 16'h2005 + 16'(i));
      end
      cycle();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_start_stop();
    snap_t s;
    do_clear();
    start = 1'b1;
    stop  = 1'b1;
    cycle();
    start = 1'b0;
    stop  = 1'b0;
    for (int m = 0; m < 2; m++) begin
      s = snap(m);
      total++;
      if (s.cap !== 1'b0) begin
        bad++;
        $display("[TB] FAIL startstop_idle dut%0d got capturing=%b want 0", m, s.cap);
      end
    end
    req_valid = 1'b1;
    address   = 16'hCAFE;
    repeat (3) cycle();
    req_valid = 1'b0;
    for (int m = 0; m < 2; m++) begin
      s = snap(m);
      total++;
      if ((s.lvl !== 5'd0) || ({s.rd, s.wr, s.dr} !== '0)) begin
        bad++;
        $display("[TB] FAIL idle_ignore dut%0d got level=%0d r=%0d w=%0d d=%0d want all 0", m, s.lvl, s.rd, s.wr, s.dr);
      end
    end
    start = 1'b1;
    cycle();
    s = snap(0);
    total++;
    if (s.cap !== 1'b1) begin
      bad++;
      $display("[TB] FAIL start_enter got capturing=%b want 1", s.cap);
    end
    stop = 1'b1;
    cycle();
    cycle();
    start = 1'b0;
    stop  = 1'b0;
    s = snap(0);
    total++;
    if (s.cap !== 1'b0) begin
      bad++;
      $display("[TB] FAIL startstop_stopped got capturing=%b want 0", s.cap);
    end
  endtask

  task automatic test_clear();
    snap_t s;
    for (int pass = 0; pass < 2; pass++) begin
      do_clear();
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
        req_valid = 1'b1;
        rw        = i[1];
        address   = 16'h3000 + 16'(i);
        cycle();
      end
      s = snap(0);
      total++;
      if ((s.lvl !== 5'd7) || (s.cap !== 1'b1)) begin
        bad++;
        $display("[TB] FAIL clear_pre%0d got level=%0d cap=%b want 7/1", pass, s.lvl, s.cap);
      end
      start     = 1'b1;
      out_ready = 1'b1;
      if (pass == 0) clear = 1'b1; else reset = 1'b1;
      cycle();
      idle_inputs();
      reset = 1'b0;
      for (int m = 0; m < 2; m++) begin
        s = snap(m);
        total++;
        if ((s.lvl !== 5'd0) || (s.valid !== 1'b0) || (s.cap !== 1'b0) || ({s.rd, s.wr, s.dr} !== '0)) begin
          bad++;
          $display("[TB] FAIL clear_post%0d dut%0d got level=%0d valid=%b cap=%b r=%0d w=%0d d=%0d want all 0",
                   pass, m, s.lvl, s.valid, s.cap, s.rd, s.wr, s.dr);
        end
      end
    end
  endtask

  task automatic test_random();
    snap_t s;
    int    ready_pct;
    ready_pct = 50;
    do_clear();
    for (int n = 0; n < 3000; n++) begin
      if ((n % 200) == 0) ready_pct = $urandom_range(0, 4) * 25;
      reset     = ($urandom_range(0, 299) == 0);
      clear     = ($urandom_range(0, 149) == 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      req_valid = ($urandom_range(0, 99) < 70);
      rw        = 1'($urandom);
      address   = 16'($urandom);
      out_ready = ($urandom_range(0, 99) < ready_pct);
      cycle();
      for (int m = 0; m < 2; m++) begin
        rec_t want_head;
        s = snap(m);
        want_head = mhead(m);
        total++;
        if ((s.valid !== (msize(m) > 0)) || (s.lvl !== 5'(msize(m)))) begin
          bad++;
          if (bad < 40) $display("[TB] FAIL rand_level dut%0d cyc=%0d got valid=%b level=%0d want valid=%b level=%0d",
                                 m, n, s.valid, s.lvl, (msize(m) > 0), msize(m));
        end
        total++;
        if ((msize(m) > 0) && ({s.rwb, s.addr} !== want_head)) begin
          bad++;
          if (bad < 40) $display("[TB] FAIL rand_head dut%0d cyc=%0d got=%h want=%h", m, n, {s.rwb, s.addr}, want_head);
        end
        total++;
        if ((s.cap !== (mst[m] == M_CAPTURE)) || (s.ovf !== mov[m])) begin
          bad++;
          if (bad < 40) $display("[TB] FAIL rand_state dut%0d cyc=%0d got cap=%b ovf=%b want cap=%b ovf=%b",
                                 m, n, s.cap, s.ovf, (mst[m] == M_CAPTURE), mov[m]);
        end
        total++;
        if ((s.rd !== 32'(mrd[m])) || (s.wr !== 32'(mwr[m])) || (s.dr !== 32'(mdr[m]))) begin
          bad++;
          if (bad < 40) $display("[TB] FAIL rand_counters dut%0d cyc=%0d got r=%0d w=%0d d=%0d want r=%0d w=%0d d=%0d",
                                 m, n, s.rd, s.wr, s.dr, mrd[m], mwr[m], mdr[m]);
        end
      end
    end
    idle_inputs();
    reset = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    mmax[0] = 64'hFFFF_FFFF;
    mmax[1] = 64'd15;
    for (int m = 0; m < 2; m++) begin
      mst[m] = M_IDLE; mrd[m] = 0; mwr[m] = 0; mdr[m] = 0; mov[m] = 1'b0;
    end
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_start_stop();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
